cpu_press_gen: RTL and testbench

Computer-player stimulus stage for Tug of War (player vs computer). Sits on both sides of `adder9Bit`:
- **Upstream:** it drives the adder with a 9-bit pseudo-random value and the two's-complement negation of the difficulty level.
- **Downstream:** it consumes the adder's carry-out and turns "random < level" into single-cycle computer button presses for the playfield logic.

---
 rtl/tow_pkg.sv | 20 ++
 rtl/adder9Bit.sv | 22 ++
 rtl/lfsr9.sv | 29 ++
 rtl/cpu_press_gen.sv | 80 ++++++++
 tb/tb_cpu_press_gen.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/tow_pkg.sv
// Shared Tug of War definitions: LFSR geometry, computer-player FSM states
// and small arithmetic helpers used by the stimulus and randomizer blocks.
package tow_pkg;

  localparam int LFSR_W = 9;
  localparam int TAP_HI = 8;
  localparam int TAP_LO = 4;

  typedef enum logic [1:0] {IDLE, SAMPLE, PRESS, GAP} cpu_state_t;

  // Fibonacci step for x^9+x^5+1: shift left, feed back the XOR of the taps.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

  function automatic logic [LFSR_W-1:0] twos_neg(input logic [LFSR_W-1:0] v);
    return ~v + LFSR_W'(1);
  endfunction

endpackage

// File: rtl/adder9Bit.sv
// 9-bit ripple-carry adder; the carry-out doubles as an unsigned a >= -b
// comparator when b carries a two's-complement negation.
module adder9Bit (
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic       cin,
  output logic [8:0] sum,
  output logic       cout
);

  logic [9:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < 9; gi++) begin : g_fa
    assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[9];

endmodule

// File: rtl/lfsr9.sv
// 9-bit maximal-length pseudo-random source; advances once per cycle with
// shift high. Shared by the computer-player and player-side randomizers.
module lfsr9
  import tow_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 9'h001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] lfsr_next_val;

  always_comb begin
    lfsr_next_val = lfsr_reg;
    if (shift) lfsr_next_val = lfsr_next(lfsr_reg);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_reg <= SEED;
    else       lfsr_reg <= lfsr_next_val;
  end

  assign q = lfsr_reg;

endmodule

// File: rtl/cpu_press_gen.sv
// Computer-player press generator: a decision tick every DIV clocks draws a
// random value, and the external adder's carry decides whether to press.
module cpu_press_gen
  import tow_pkg::*;
#(
  parameter int              DIV  = 12500000,
  parameter logic [LFSR_W-1:0] SEED = 9'h001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] level,
  input  logic              cout_in,
  output logic [LFSR_W-1:0] op_a,
  output logic [LFSR_W-1:0] op_b,
  output logic              press,
  output logic              tick
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             tick_reg, tick_next;
  cpu_state_t       state_reg, state_next;
  logic             level_nz;

  // tick is raised one count early so that it is high while the count sits
  // at DIV-1, putting the first tick in cycle DIV after reset.
  always_comb begin
    cnt_next  = cnt_reg;
    tick_next = 1'b0;
    if (enable) begin
      tick_next = (cnt_reg == CNT_PRE);
      cnt_next  = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      tick_reg <= tick_next;
    end
  end

  lfsr9 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .shift(tick_reg),
    .q    (op_a)
  );

  assign op_b     = twos_neg(level);
  // level 0 negates to 0, so the carry is 0 and would otherwise look like a hit.
  assign level_nz = |level;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick_reg) state_next = SAMPLE;
      SAMPLE:  state_next = (level_nz && !cout_in) ? PRESS : IDLE;
      PRESS:   state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  assign press = (state_reg == PRESS);
  assign tick  = tick_reg;

endmodule

// File: tb/tb_cpu_press_gen.sv
// Directed bench for cpu_press_gen with the real adder in the loop; a
// tick/press model derived from enabled-cycle counts checks every cycle.
module tb_cpu_press_gen;

  localparam int DIV = 5;

  logic       clk, reset, enable, cout_in, press, tick;
  logic [8:0] level, op_a, op_b, sum;

  cpu_press_gen #(.DIV(DIV), .SEED(9'h001)) dut (
    .clk(clk), .reset(reset), .enable(enable), .level(level),
    .cout_in(cout_in), .op_a(op_a), .op_b(op_b), .press(press), .tick(tick)
  );

  adder9Bit u_add (.a(op_a), .b(op_b), .cin(1'b0), .sum(sum), .cout(cout_in));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int tick_seen = 0;
  int press_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] seq [1024];
  int  cyc, en_count, ticks, free_at, sample_at, press_at;
  bit  m_tick, en_s, rst_s;
  int  lv, exp_a;

  initial begin
    seq[0] = 9'h001;
    for (int i = 0; i < 1023; i++)
      seq[i+1] = {seq[i][7:0], seq[i][8] ^ seq[i][4]};
  end

  always @(posedge clk) begin
    en_s  = enable;
    rst_s = reset;
    #1;
    if (rst_s || reset) begin
      cyc = 1; en_count = 0; ticks = 0; m_tick = 0;
      free_at = 0; sample_at = -1; press_at = -1;
    end else begin
      cyc++;
      if (m_tick) begin
        ticks++;
        if (cyc - 1 >= free_at) begin
          sample_at = cyc;
          free_at   = cyc + 3;
        end
      end
      if (en_s) en_count++;
      m_tick = en_s && (en_count % DIV == DIV - 1);
      lv    = int'(level);
      exp_a = int'(seq[ticks]);
      if (cyc == sample_at) begin
        chk("m_cout", int'(cout_in), (lv != 0 && exp_a >= lv) ? 1 : 0);
        if (lv != 0 && exp_a < lv) press_at = cyc + 1;
      end
      chk("m_tick",  int'(tick),  int'(m_tick));
      chk("m_press", int'(press), (cyc == press_at) ? 1 : 0);
      chk("m_op_a",  int'(op_a),  exp_a);
      chk("m_op_b",  int'(op_b),  (512 - lv) % 512);
      chk("m_sum",   int'(sum),   (exp_a - lv + 512) % 512);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (tick)  tick_seen++;
    if (press) press_seen++;
  endtask

  // Returns the cycle number (counting the current cycle as 1) in which tick is seen.
  task automatic wait_tick(output int c);
    int n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 50);
    if (!tick) chk("tick_timeout", 0, 1);
    c = n + 1;
  endtask

  task automatic do_reset(input logic [8:0] lvl);
    @(negedge clk);
    reset = 1'b1;
    level = lvl;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [8:0] exp5 [5] = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
  int c, first_ret, zeros;

  initial begin
    reset = 1'b1; enable = 1'b0; level = 9'd511;
    repeat (3) @(negedge clk);
    enable = 1'b1; reset = 1'b0;

    // level=511, first decision presses
    wait_tick(c);
    chk("first_tick_cycle", c, 5);
    step();
    chk("t1_op_a", int'(op_a), 9'h002);
    chk("t1_op_b", int'(op_b), 9'h001);
    chk("t1_cout", int'(cout_in), 0);
    step();
    chk("t1_press_hi", int'(press), 1);
    step();
    chk("t1_press_gap", int'(press), 0);
    $display("phase level511: first press checked at %0t", $time);

    // asynchronous reset while press is high
    wait_tick(c);
    step();
    step();
    chk("t2_press_hi", int'(press), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_op_a",  int'(op_a), 9'h001);
    chk("rst_press", int'(press), 0);
    chk("rst_tick",  int'(tick), 0);
    level = 9'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("phase reset: mid-press reset checked at %0t", $time);

    // level=0: LFSR sequence pinned, never presses
    press_seen = 0;
    wait_tick(c);
    chk("rst_first_tick_cycle", c, 5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_tick(c);
      step();
      chk($sformatf("seq%0d", i), int'(op_a), int'(exp5[i]));
    end
    chk("l0_op_b", int'(op_b), 0);
    chk("l0_cout", int'(cout_in), 0);
    repeat (95) wait_tick(c);
    chk("l0_presses", press_seen, 0);
    $display("phase level0: 100 ticks, %0d presses at %0t", press_seen, $time);

    // level=1: full period, no zero, never presses
    do_reset(9'd1);
    press_seen = 0; first_ret = 0; zeros = 0;
    for (int k = 1; k <= 600; k++) begin
      wait_tick(c);
      step();
      if (op_a == 9'h000) zeros++;
      if (op_a == 9'h001 && first_ret == 0) first_ret = k;
    end
    chk("l1_period", first_ret, 511);
    chk("l1_zeros", zeros, 0);
    chk("l1_presses", press_seen, 0);
    chk("l1_op_b", int'(op_b), 9'h1FF);
    $display("phase level1: period %0d, %0d presses at %0t", first_ret, press_seen, $time);

    // enable dropped in the cycle after a tick
    do_reset(9'd511);
    wait_tick(c);
    chk("f_first_tick_cycle", c, 5);
    step();
    #1 enable = 1'b0;
    press_seen = 0; tick_seen = 0;
    repeat (20) step();
    chk("f_press_count", press_seen, 1);
    chk("f_ticks", tick_seen, 0);
    chk("f_op_a_hold", int'(op_a), 9'h002);
    @(negedge clk);
    enable = 1'b1;
    wait_tick(c);
    chk("f_reenable_cycle", c, 5);
    step();
    chk("f_op_a_next", int'(op_a), 9'h004);
    repeat (3) step();
    $display("phase enable: press completed, re-enable tick after %0d cycles", c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
